fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: DATA_W, default 8, width of the FIFO read data and the output stream data.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low; asserted at rst=0.
REQ-004 Port: buf_out  input  DATA_W  FIFO read data; valid exactly one cycle after rd_en=1.
REQ-005 Port: buf_empty  input  1  FIFO empty flag.
REQ-006 Port: rd_en  output  1  FIFO pop strobe, one byte per cycle asserted.
REQ-007 Port: drain_en  input  1  enables new FIFO reads; 0 stops new reads, and in-flight and buffered data still deliver.
REQ-008 Port: m_data  output  DATA_W  output stream data.
REQ-009 Port: m_valid  output  1  m_data holds a valid word.
REQ-010 Port: m_ready  input  1  downstream accepts; transfer = m_valid & m_ready.
REQ-011 Port: rd_count  output  8  count of completed output transfers, modulo 256.

Function
REQ-012 The block SHALL convert the FIFO's 1-cycle-latency pop interface into a valid/ready stream, using a 2-entry output buffer.
REQ-013 Buffer occupancy state SHALL be one of EMPTY(0), ONE(1), TWO(2).
REQ-014 inflight SHALL be a register equal to rd_en from the previous cycle.
REQ-015 rd_en SHALL equal rst & drain_en & ~buf_empty & ((occ + inflight - pop) < 2), where pop = m_valid & m_ready (combinational from m_ready).
REQ-016 rd_en SHALL never be 1 while buf_empty=1.
REQ-017 When inflight=1, buf_out SHALL be captured into the buffer tail in that cycle.
REQ-018 Occupancy transitions: capture & ~pop -> +1; pop & ~capture -> -1; capture & pop, or neither -> unchanged.
REQ-019 A capture SHALL never occur with occ=TWO and no pop; the credit rule in REQ-015 guarantees this, and an assertion SHALL check it.
REQ-020 m_valid SHALL equal (occ != EMPTY); m_data SHALL be the buffer head.
REQ-021 While m_valid=1 and m_ready=0, m_data and m_valid SHALL hold stable.
REQ-022 Output order SHALL equal FIFO pop order, with no duplication or loss.
REQ-023 Sustained throughput SHALL be 1 word/cycle when the FIFO is non-empty and m_ready=1.
REQ-024 Latency from the first rd_en to m_valid SHALL be 2 cycles (capture edge, then registered head).
REQ-025 rd_count SHALL increment by 1 per transfer and wrap 255 -> 0.
REQ-026 drain_en falling while inflight=1 SHALL still capture that word.

Reset
REQ-027 On rst=0, the block SHALL asynchronously set occ=EMPTY, inflight=0, m_valid=0, m_data=0, rd_count=0 and rd_en=0.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words; the first post-reset rd_en SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-029 A shared package fifo_pkg SHALL hold DATA_W default, the occupancy enum (EMPTY/ONE/TWO) and the rd_count width constant.
REQ-030 A 2-entry head/tail register pair SHALL be a sub-module named out_skid_buf; fifo_reader SHALL hold the credit logic, inflight and rd_count.

Verification
REQ-031 Scenario: FIFO preloaded with 100,64,36; drain_en=1; m_ready=1 -> m_data sequence 100,64,36 on consecutive cycles starting 2 cycles after the first rd_en; rd_count=3.
REQ-032 Scenario: buf_empty=1 throughout -> rd_en stays 0 and m_valid stays 0.
REQ-033 Scenario: 4 words 12,55,100,64; m_ready=0 for 5 cycles -> occ reaches TWO, rd_en stays 0, m_data=12 stable; m_ready=1 -> all 4 delivered in order.
REQ-034 Scenario: drain_en dropped in the cycle after rd_en -> that word is delivered and no further rd_en occurs.
REQ-035 Scenario: rst=0 pulsed while occ=TWO -> m_valid=0 and rd_count=0 immediately, without a clock edge.
REQ-036 Scenario: 257 continuous transfers -> rd_count=1 and no gaps in m_valid.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: data width default, occupancy states
// and the width of the transfer counter.
package fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry head/tail output buffer. The head always drives the stream data;
// the tail only holds a word while the head is blocked by the downstream side.
module out_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output occ_t              occ,
   output logic [DATA_W-1:0] head
);

   occ_t              occ_nxt;
   logic [DATA_W-1:0] tail;

   // Occupancy state register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ <= EMPTY;
      end else begin
         occ <= occ_nxt;
      end
   end

   // Occupancy next state: a capture adds a word, a pop removes one, both cancel.
   always_comb begin
      occ_nxt = occ;
      if (capture && !pop) begin
         case (occ)
            EMPTY:   occ_nxt = ONE;
            ONE:     occ_nxt = TWO;
            default: occ_nxt = TWO;
         endcase
      end else if (pop && !capture) begin
         case (occ)
            TWO:     occ_nxt = ONE;
            default: occ_nxt = EMPTY;
         endcase
      end
   end

   // Head/tail data movement: new words land in the first free slot, and a pop
   // promotes the tail into the head so the stream order is preserved.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
      end else if (capture && !pop) begin
         if (occ == EMPTY) begin
            head <= din;
         end else begin
            tail <= din;
         end
      end else if (pop && !capture) begin
         head <= tail;
      end else if (capture && pop) begin
         if (occ == TWO) begin
            head <= tail;
            tail <= din;
         end else begin
            head <= din;
         end
      end
   end

   // The upstream credit check must never let a word arrive into a full buffer.
   capture_into_full: assert property (@(posedge clk) disable iff (!rst)
      !(capture && !pop && (occ == TWO)));

endmodule

// File: rtl/fifo_reader.sv
// Turns a FIFO with one-cycle read latency into a valid/ready stream. Reads are
// issued only when the word is guaranteed a slot in the two-entry output buffer.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] buf_out,
   input  logic              buf_empty,
   output logic              rd_en,
   input  logic              drain_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  rd_count
);

   occ_t       occ;
   logic       inflight;
   logic       pop;
   logic [2:0] credit_sum;

   assign m_valid = (occ != EMPTY);
   assign pop     = m_valid & m_ready;

   // Words already committed to the buffer (stored plus in flight, minus the one
   // leaving this cycle); a new read is allowed only while this stays below two.
   assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign rd_en      = rst & drain_en & ~buf_empty & (credit_sum < 3'd2);

   // Remember last cycle's read so the FIFO data is captured when it appears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rd_en;
      end
   end

   // Count completed output transfers, wrapping naturally at the counter width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count <= '0;
      end else if (pop) begin
         rd_count <= rd_count + CNT_W'(1);
      end
   end

   out_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .capture (inflight),
      .pop     (pop),
      .din     (buf_out),
      .occ     (occ),
      .head    (m_data)
   );

endmodule
